// File: rtl/conv2d_layer_sequencer.sv
// Conv2d layer loop-nest sequencer: output channel -> input channel -> row -> column.
// Optional performance counters are enabled by defining CONV_SEQ_PERF_CNT_EN.
module conv2d_layer_sequencer #(
  parameter int unsigned IMG_WIDTH = 64,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_in_channels,
  input  logic [CNT_WIDTH-1:0] cfg_out_channels,
  input  logic [CNT_WIDTH-1:0] cfg_height,
  input  logic                 kernel_valid,
  input  logic                 pix_valid,
  input  logic                 PE_ready,
  input  logic                 PE_with_buffers_IDLE,
  output logic                 Load_kernel_reg,
  output logic                 kernel_ack,
  output logic                 Stream_mid_row,
  output logic                 Stream_last_row,
  output logic                 Done_1row,
  output logic                 last_channel,
  output logic [CNT_WIDTH-1:0] b_counter_output,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
`ifdef CONV_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          active_cycles
`endif
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_WAIT_PE, S_STREAM, S_ROW_END, S_DRAIN, S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] cin_q, cin_d, cout_q, cout_d, height_q, height_d;
  logic [CNT_WIDTH-1:0] ic_q, ic_d, row_q, row_d, oc_q, oc_d;
  logic [COL_W-1:0]     col_q, col_d;

  logic load_d, mid_d, last_d, row_done_d, lastch_d, busy_d, done_d, cfg_err_d;
  logic cfg_ok, last_row, last_ic, last_oc;

  assign cfg_ok   = (|cfg_in_channels) && (|cfg_out_channels) && (|cfg_height);
  assign last_row = (row_q == height_q - ONE);
  assign last_ic  = (ic_q == cin_q - ONE);
  assign last_oc  = (oc_q == cout_q - ONE);

  assign b_counter_output = oc_q;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d    = state_q;
    cin_d      = cin_q;
    cout_d     = cout_q;
    height_d   = height_q;
    ic_d       = ic_q;
    row_d      = row_q;
    oc_d       = oc_q;
    col_d      = col_q;
    load_d     = 1'b0;
    mid_d      = 1'b0;
    last_d     = 1'b0;
    row_done_d = 1'b0;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    busy_d     = 1'b0;
    lastch_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            cin_d    = cfg_in_channels;
            cout_d   = cfg_out_channels;
            height_d = cfg_height;
            ic_d     = '0;
            row_d    = '0;
            oc_d     = '0;
            col_d    = '0;
            state_d  = S_LOAD_K;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD_K: begin
        if (kernel_valid) begin
          load_d  = 1'b1;
          state_d = S_WAIT_PE;
        end
      end
      S_WAIT_PE: begin
        if (PE_ready) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (pix_valid) begin
          mid_d  = !last_row;
          last_d = last_row;
          if (col_q == COL_LAST) state_d = S_ROW_END;
          else                   col_d   = col_q + COL_W'(1);
        end
      end
      S_ROW_END: begin
        row_done_d = 1'b1;
        col_d      = '0;
        if (!last_row) begin
          row_d   = row_q + ONE;
          state_d = S_WAIT_PE;
        end else begin
          row_d = '0;
          if (!last_ic) begin
            ic_d    = ic_q + ONE;
            state_d = S_LOAD_K;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Output BRAM has been drained with bias once the PE wrapper reports idle
        if (PE_with_buffers_IDLE) begin
          if (!last_oc) begin
            oc_d    = oc_q + ONE;
            ic_d    = '0;
            state_d = S_LOAD_K;
          end else begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE) && (state_d != S_FIN);
    lastch_d = busy_d && (ic_d == cin_d - ONE);
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q         <= S_IDLE;
      cin_q           <= '0;
      cout_q          <= '0;
      height_q        <= '0;
      ic_q            <= '0;
      row_q           <= '0;
      oc_q            <= '0;
      col_q           <= '0;
      Load_kernel_reg <= 1'b0;
      kernel_ack      <= 1'b0;
      Stream_mid_row  <= 1'b0;
      Stream_last_row <= 1'b0;
      Done_1row       <= 1'b0;
      last_channel    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cin_q           <= cin_d;
      cout_q          <= cout_d;
      height_q        <= height_d;
      ic_q            <= ic_d;
      row_q           <= row_d;
      oc_q            <= oc_d;
      col_q           <= col_d;
      Load_kernel_reg <= load_d;
      kernel_ack      <= load_d;
      Stream_mid_row  <= mid_d;
      Stream_last_row <= last_d;
      Done_1row       <= row_done_d;
      last_channel    <= lastch_d;
      busy            <= busy_d;
      done            <= done_d;
      cfg_err         <= cfg_err_d;
    end
  end

`ifdef CONV_SEQ_PERF_CNT_EN
  logic start_acc_c, stall_c;

  assign start_acc_c = (state_q == S_IDLE) && start && cfg_ok;
  assign stall_c     = (state_q == S_WAIT_PE)
                    || ((state_q == S_LOAD_K) && !kernel_valid)
                    || ((state_q == S_STREAM) && !pix_valid);

  // Saturating counters; they hold after done until the next accepted start
  always_ff @(posedge clk) begin
    if (Reset || start_acc_c) begin
      stall_cycles  <= '0;
      active_cycles <= '0;
    end else begin
      if (stall_c && (stall_cycles != '1)) stall_cycles  <= stall_cycles + 32'd1;
      if (busy && (active_cycles != '1))   active_cycles <= active_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv2d_layer_sequencer.sv
// Scoreboard bench for conv2d_layer_sequencer: a loop-nest reference model queues the
// expected strobe sequence and a negedge monitor compares every output event against it.
module tb_conv2d_layer_sequencer;

  localparam int W = 4;
  localparam int M_HIGH = 0, M_RAND = 1, M_PAT = 2;

  localparam logic [6:0] EV_LOAD = 7'b1100000;
  localparam logic [6:0] EV_MID  = 7'b0010000;
  localparam logic [6:0] EV_LAST = 7'b0001000;
  localparam logic [6:0] EV_ROW  = 7'b0000100;
  localparam logic [6:0] EV_DONE = 7'b0000010;
  localparam logic [6:0] EV_ERR  = 7'b0000001;

  logic       clk, Reset, start;
  logic [7:0] cfg_in_channels, cfg_out_channels, cfg_height;
  logic       kernel_valid, pix_valid, PE_ready, PE_with_buffers_IDLE;
  logic       Load_kernel_reg, kernel_ack, Stream_mid_row, Stream_last_row, Done_1row;
  logic       last_channel, busy, done, cfg_err;
  logic [7:0] b_counter_output;
`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0] stall_cycles, active_cycles;
`endif

  conv2d_layer_sequencer #(.IMG_WIDTH(W), .CNT_WIDTH(8)) dut (
    .clk(clk), .Reset(Reset), .start(start),
    .cfg_in_channels(cfg_in_channels), .cfg_out_channels(cfg_out_channels),
    .cfg_height(cfg_height),
    .kernel_valid(kernel_valid), .pix_valid(pix_valid), .PE_ready(PE_ready),
    .PE_with_buffers_IDLE(PE_with_buffers_IDLE),
    .Load_kernel_reg(Load_kernel_reg), .kernel_ack(kernel_ack),
    .Stream_mid_row(Stream_mid_row), .Stream_last_row(Stream_last_row),
    .Done_1row(Done_1row), .last_channel(last_channel),
    .b_counter_output(b_counter_output), .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef CONV_SEQ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .active_cycles(active_cycles)
`endif
  );

  typedef struct {
    logic [6:0] ev;
    bit         chk_lc;
    bit         lc;
    bit         chk_oc;
    logic [7:0] oc;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, mode = M_HIGH, s_cyc = 0;
  bit idle_hold_low = 0;
  int load_cnt = 0, row_cnt = 0, strobe_cnt = 0, done_cnt = 0, ev_cnt = 0, done_cyc = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake driver: inputs change 1 time unit after each rising edge
  initial begin
    kernel_valid = 0; pix_valid = 0; PE_ready = 0; PE_with_buffers_IDLE = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (mode)
        M_RAND: begin
          kernel_valid         = ($urandom_range(0, 99) < 60);
          pix_valid            = ($urandom_range(0, 99) < 65);
          PE_ready             = ($urandom_range(0, 99) < 60);
          PE_with_buffers_IDLE = !idle_hold_low && ($urandom_range(0, 99) < 50);
        end
        M_PAT: begin
          kernel_valid = 1; PE_ready = 1; pix_valid = ((cyc % 3) == 0);
          PE_with_buffers_IDLE = !idle_hold_low;
        end
        default: begin
          kernel_valid = 1; pix_valid = 1; PE_ready = 1;
          PE_with_buffers_IDLE = !idle_hold_low;
        end
      endcase
    end
  end

  // Monitor: every cycle carrying an output event is one scoreboard comparison
  logic [6:0] mon_ev;
  exp_t       mon_e;
  bit         mon_ok;
  always @(negedge clk) begin
    mon_ev = {Load_kernel_reg, kernel_ack, Stream_mid_row, Stream_last_row, Done_1row, done, cfg_err};
    if (mon_ev != 7'd0) begin
      ev_cnt++;
      if (Load_kernel_reg) load_cnt++;
      if (Done_1row) row_cnt++;
      if (Stream_mid_row || Stream_last_row) strobe_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got ev=%b oc=%0d lc=%0b, required no event", mon_ev, b_counter_output, last_channel);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ok = (mon_ev == mon_e.ev)
              && (!mon_e.chk_lc || (last_channel == mon_e.lc))
              && (!mon_e.chk_oc || (b_counter_output == mon_e.oc));
        if (!mon_ok) begin
          n_err++;
          $display("FAIL event_seq @cyc %0d: got ev=%b oc=%0d lc=%0b, required ev=%b oc=%0d lc=%0b",
                   cyc, mon_ev, b_counter_output, last_channel, mon_e.ev, mon_e.oc, mon_e.lc);
        end
      end
    end
  end

  function automatic void push_ev(logic [6:0] ev, bit chk_lc, bit lc, bit chk_oc, int oc);
    exp_t e;
    e.ev = ev; e.chk_lc = chk_lc; e.lc = lc; e.chk_oc = chk_oc; e.oc = 8'(oc);
    exp_q.push_back(e);
  endfunction

  // Reference model: loop nest expressed directly as the expected event order
  function automatic void push_layer(int ci, int co, int h);
    if (ci == 0 || co == 0 || h == 0) begin
      push_ev(EV_ERR, 0, 0, 0, 0);
      return;
    end
    for (int oc = 0; oc < co; oc++) begin
      for (int ic = 0; ic < ci; ic++) begin
        push_ev(EV_LOAD, 1, ic == ci - 1, 1, oc);
        for (int r = 0; r < h; r++) begin
          for (int c = 0; c < W; c++)
            push_ev((r == h - 1) ? EV_LAST : EV_MID, 1, ic == ci - 1, 1, oc);
          push_ev(EV_ROW, 0, 0, 1, oc);
        end
      end
    end
    push_ev(EV_DONE, 0, 0, 1, co - 1);
  endfunction

  // Cycle timeline with every handshake high and pix_valid = (cycle % 3 == 0)
  function automatic void model_pat(input int e, input int ci, input int co, input int h,
                                    output int t_fin, output int stall);
    int t = e, gaps = 0, rows = 0, beats;
    for (int oc = 0; oc < co; oc++) begin
      for (int ic = 0; ic < ci; ic++) begin
        t++;
        for (int r = 0; r < h; r++) begin
          t++;
          beats = 0;
          while (beats < W) begin
            if ((t % 3) == 0) beats++; else gaps++;
            t++;
          end
          t++;
          rows++;
        end
      end
      t++;
    end
    t_fin = t;
    stall = rows + gaps;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic start_layer(input int ci, input int co, input int h);
    push_layer(ci, co, h);
    @(posedge clk); #2;
    cfg_in_channels = 8'(ci); cfg_out_channels = 8'(co); cfg_height = 8'(h);
    start = 1; s_cyc = cyc;
    @(posedge clk); #2;
    start = 0;
    @(negedge clk);
    check("busy_after_start", busy, (ci != 0 && co != 0 && h != 0) ? 1 : 0);
  endtask

  task automatic wait_done(input int d0, input string name);
    int k = 0;
    while (done_cnt == d0 && k < 4000) begin @(posedge clk); k++; end
    n_vec++;
    if (done_cnt == d0) begin
      n_err++;
      $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, k);
    end
    #2;
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy_low"}, busy, 0);
  endtask

  task automatic run_layer(input int ci, input int co, input int h, input string name);
    int d0 = done_cnt, l0 = load_cnt, r0 = row_cnt;
    start_layer(ci, co, h);
    wait_done(d0, name);
    check({name, "_loads"}, load_cnt - l0, ci * co);
    check({name, "_rows"}, row_cnt - r0, ci * co * h);
  endtask

  int t_fin, stall_exp, d0, l0, e0, k, c_rel;

  initial begin
    Reset = 1; start = 0;
    cfg_in_channels = 0; cfg_out_channels = 0; cfg_height = 0;
    repeat (3) @(posedge clk);
    #2 Reset = 0;
    @(negedge clk);
    check("reset_outputs", {Load_kernel_reg, kernel_ack, Stream_mid_row, Stream_last_row, Done_1row,
                            last_channel, b_counter_output, busy, done, cfg_err}, 0);
`ifdef CONV_SEQ_PERF_CNT_EN
    check("reset_perf", {stall_cycles, active_cycles}, 0);
`endif

    mode = M_HIGH;
    run_layer(1, 1, 2, "basic");
    run_layer(3, 2, 2, "multi_ch");

    // Gapped pixel stream: done cycle and stall count follow the timeline model
    mode = M_PAT;
    d0 = done_cnt;
    start_layer(2, 1, 2);
    model_pat(s_cyc + 1, 2, 1, 2, t_fin, stall_exp);
    wait_done(d0, "pattern");
    check("pattern_done_cycle", done_cyc, t_fin);
`ifdef CONV_SEQ_PERF_CNT_EN
    check("pattern_stall_cycles", stall_cycles, stall_exp);
    check("pattern_active_cycles", active_cycles, t_fin - (s_cyc + 1));
`endif
    mode = M_HIGH;

    // Rejected configurations
    start_layer(2, 1, 0);
    repeat (3) @(posedge clk); #2;
    check("cfg_err_h0_queue", exp_q.size(), 0);
    check("cfg_err_h0_busy", busy, 0);
    start_layer(0, 2, 2);
    repeat (3) @(posedge clk); #2;
    check("cfg_err_in0_queue", exp_q.size(), 0);

    // start while busy is ignored
    mode = M_RAND;
    d0 = done_cnt; l0 = load_cnt;
    start_layer(2, 2, 2);
    repeat (10) @(posedge clk);
    #2;
    cfg_in_channels = 1; cfg_out_channels = 1; cfg_height = 1; start = 1;
    @(posedge clk); #2 start = 0;
    wait_done(d0, "start_busy");
    check("start_busy_loads", load_cnt - l0, 4);

    // Reset in the middle of row 1 of output channel 1
    mode = M_HIGH;
    d0 = done_cnt; e0 = strobe_cnt;
    start_layer(1, 2, 2);
    k = 0;
    while (strobe_cnt < e0 + 14 && k < 500) begin @(posedge clk); k++; end
    check("reset_reached_row1", strobe_cnt >= e0 + 14, 1);
    #2 Reset = 1;
    @(posedge clk); #2 Reset = 0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_outputs", {Load_kernel_reg, kernel_ack, Stream_mid_row, Stream_last_row, Done_1row,
                               last_channel, b_counter_output, busy, done, cfg_err}, 0);
`ifdef CONV_SEQ_PERF_CNT_EN
    check("midreset_perf", {stall_cycles, active_cycles}, 0);
`endif
    repeat (20) @(posedge clk);
    check("midreset_no_done", done_cnt, d0);
    mode = M_RAND;
    run_layer(2, 1, 3, "post_reset");

    // Drain held off for 50 cycles
    mode = M_HIGH; idle_hold_low = 1;
    d0 = done_cnt; e0 = row_cnt;
    start_layer(2, 1, 1);
    k = 0;
    while (row_cnt < e0 + 2 && k < 500) begin @(posedge clk); k++; end
    l0 = ev_cnt;
    repeat (50) @(posedge clk);
    #2;
    check("drain_no_events", ev_cnt - l0, 0);
    check("drain_busy", busy, 1);
    c_rel = cyc;
    idle_hold_low = 0;
    wait_done(d0, "drain");
    check("drain_done_cycle", done_cyc, c_rel + 2);

    // Random layers under random handshakes
    mode = M_RAND;
    for (int i = 0; i < 6; i++)
      run_layer(int'($urandom_range(1, 3)), int'($urandom_range(1, 2)), int'($urandom_range(1, 3)), "random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "bench timeout");
  end

endmodule
